// File: rtl/bpu_bht_btb_if.sv
// Lookup and training bus between fetch/EX and the bpu_bht_btb branch predictor.
// The master side drives the PCs and resolved outcomes, and the predictor answers on the slave side.
interface bpu_bht_btb_if #(
    parameter int AW = 32
);
    logic [AW-1:0] lkp_pc_i;
    logic          lkp_hit_o;
    logic          lkp_taken_o;
    logic [AW-1:0] lkp_target_o;
    logic          upd_en_i;
    logic [AW-1:0] upd_pc_i;
    logic          upd_taken_i;
    logic [AW-1:0] upd_target_i;
    logic          busy_o;

    modport master (
        output lkp_pc_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  lkp_hit_o, lkp_taken_o, lkp_target_o, busy_o
    );

    modport slave (
        input  lkp_pc_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i,
        output lkp_hit_o, lkp_taken_o, lkp_target_o, busy_o
    );
endinterface

// File: rtl/bpu_bht_btb.sv
// Direct-mapped BHT/BTB with a combinational lookup, EX-stage training and an INIT sweep after reset.
// Optional feature: define BPU_GHR_EN to XOR a global history register into the table index.
module bpu_bht_btb #(
    parameter int AW      = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 6
) (
    input  logic           clk,
    input  logic           rst,
    bpu_bht_btb_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_MAX >> 1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_WNT + CNT_W'(1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [CNT_W-1:0] cnt;
        logic [AW-1:0]    tgt;
    } entry_t;

    entry_t           bht_q [ENTRIES];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [IDX_W-1:0] lkp_idx, upd_idx, wr_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;
    entry_t           lkp_e, upd_e, wr_e;
    logic             wr_en, upd_hit, run;
    logic             unused_pc_bits;

    assign run     = (state_q == ST_RUN);
    assign lkp_tag = bus.lkp_pc_i[2+IDX_W +: TAG_W];
    assign upd_tag = bus.upd_pc_i[2+IDX_W +: TAG_W];
    assign unused_pc_bits = ^{bus.lkp_pc_i, bus.upd_pc_i};

`ifdef BPU_GHR_EN
    logic [GHR_W-1:0] ghr_q;

    assign lkp_idx = bus.lkp_pc_i[2 +: IDX_W] ^ IDX_W'(ghr_q);
    assign upd_idx = bus.upd_pc_i[2 +: IDX_W] ^ IDX_W'(ghr_q);

    // History shifts in every resolved outcome seen in RUN and restarts from zero on every INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (state_q == ST_INIT) begin
            ghr_q <= '0;
        end else if (bus.upd_en_i) begin
            ghr_q <= (ghr_q << 1) | GHR_W'(bus.upd_taken_i);
        end
    end
`else
    localparam int unused_ghr_w = GHR_W;

    assign lkp_idx = bus.lkp_pc_i[2 +: IDX_W];
    assign upd_idx = bus.upd_pc_i[2 +: IDX_W];
`endif

    // The table contents are untrustworthy until the sweep finishes, so nothing hits outside RUN.
    assign lkp_e            = bht_q[lkp_idx];
    assign bus.lkp_hit_o    = run & lkp_e.valid & (lkp_e.tag == lkp_tag);
    assign bus.lkp_taken_o  = bus.lkp_hit_o & lkp_e.cnt[CNT_W-1];
    assign bus.lkp_target_o = bus.lkp_taken_o ? lkp_e.tgt : bus.lkp_pc_i + AW'(4);
    assign bus.busy_o       = (state_q == ST_INIT);

    assign upd_e   = bht_q[upd_idx];
    assign upd_hit = upd_e.valid & (upd_e.tag == upd_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // One write port: the INIT sweep owns it, otherwise a resolved branch may train one entry.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = upd_idx;
        wr_e   = upd_e;
        if (state_q == ST_INIT) begin
            wr_en  = 1'b1;
            wr_idx = sweep_q;
            wr_e   = '0;
            wr_e.cnt = CNT_WNT;
        end else if (bus.upd_en_i) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (bus.upd_taken_i) begin
                    wr_e.cnt = (upd_e.cnt == CNT_MAX) ? upd_e.cnt : upd_e.cnt + CNT_W'(1);
                    wr_e.tgt = bus.upd_target_i;
                end else begin
                    wr_e.cnt = (upd_e.cnt == '0) ? upd_e.cnt : upd_e.cnt - CNT_W'(1);
                end
            end else if (bus.upd_taken_i) begin
                wr_en      = 1'b1;
                wr_e.valid = 1'b1;
                wr_e.tag   = upd_tag;
                wr_e.cnt   = CNT_WT;
                wr_e.tgt   = bus.upd_target_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bht_q[wr_idx] <= wr_e;
        end
    end
endmodule

// File: tb/tb_bpu_bht_btb.sv
// Self-checking bench for bpu_bht_btb: directed vector table, reset/INIT sequences, random training
// against a plain-arithmetic predictor model (default build, BPU_GHR_EN undefined).
module tb_bpu_bht_btb;
    localparam int AW      = 32;
    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CHALF   = 1 << (CNT_W - 1);

    typedef struct {
        logic        en;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] utg;
        logic [31:0] lpc;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic        cur_en;
    logic [31:0] cur_upc, cur_utg, cur_lpc;
    logic        cur_tk;

    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          init_left;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bpu_bht_btb_if #(.AW(AW)) bus ();

    bpu_bht_btb #(
        .AW(AW), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W), .GHR_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % 32'(1 << TAG_W));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_cnt[i]   = CHALF - 1;
            m_tgt[i]   = '0;
        end
        init_left = ENTRIES;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic hit,
                                      output logic taken, output logic [31:0] tgt);
        int i = idx_of(pc);
        hit   = (init_left == 0) && m_valid[i] && (m_tag[i] == tag_of(pc));
        taken = hit && (m_cnt[i] >= CHALF);
        tgt   = taken ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_step(input logic en, input logic [31:0] pc, input logic tk,
                                   input logic [31:0] tg);
        int i = idx_of(pc);
        int t = tag_of(pc);
        if (init_left > 0) begin
            init_left--;
            return;
        end
        if (!en) return;
        if (m_valid[i] && m_tag[i] == t) begin
            if (tk) begin
                if (m_cnt[i] < CMAX) m_cnt[i]++;
                m_tgt[i] = tg;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_cnt[i]   = CHALF;
            m_tgt[i]   = tg;
        end
    endfunction

    function automatic vec_t mk(logic en, logic [31:0] upc, logic tk, logic [31:0] utg,
                                logic [31:0] lpc, logic hit, logic taken, logic [31:0] tgt);
        vec_t v;
        v.en = en; v.upc = upc; v.tk = tk; v.utg = utg;
        v.lpc = lpc; v.hit = hit; v.taken = taken; v.tgt = tgt;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic eh, input logic et,
                               input logic [31:0] eg, input logic eb);
        checkBit({name, ".hit"}, bus.lkp_hit_o, eh);
        checkBit({name, ".taken"}, bus.lkp_taken_o, et);
        checkWord({name, ".target"}, bus.lkp_target_o, eg);
        checkBit({name, ".busy"}, bus.busy_o, eb);
    endtask

    // Called at a falling edge; inputs settle for 1 time unit before the outputs are compared.
    task automatic applyStimulus(input logic en, input logic [31:0] upc, input logic tk,
                                 input logic [31:0] utg, input logic [31:0] lpc);
        cur_en = en; cur_upc = upc; cur_tk = tk; cur_utg = utg; cur_lpc = lpc;
        bus.upd_en_i     = en;
        bus.upd_pc_i     = upc;
        bus.upd_taken_i  = tk;
        bus.upd_target_i = utg;
        bus.lkp_pc_i     = lpc;
        #1;
    endtask

    task automatic finishCycle();
        @(posedge clk);
        m_step(cur_en, cur_upc, cur_tk, cur_utg);
        @(negedge clk);
    endtask

    // Trains 0x100 as taken throughout INIT, which must leave no trace once RUN is reached.
    task automatic runInit(input string name);
        int count = 0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(init_left > 0, 32'h100, 1'b1, 32'h80, 32'h100);
            if (!bus.busy_o) break;
            count++;
            checkOutput($sformatf("%s.c%0d", name, c), 1'b0, 1'b0, 32'h104, 1'b1);
            finishCycle();
        end
        checkWord({name, ".busy_cycles"}, count, ENTRIES);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        eh, et;
        logic [31:0] eg;

        vecs.push_back(mk(1, 32'h100, 1, 32'h080, 32'h100, 0, 0, 32'h104));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h100, 1, 1, 32'h080));
        vecs.push_back(mk(1, 32'h100, 0, 32'h000, 32'h100, 1, 1, 32'h080));
        vecs.push_back(mk(1, 32'h100, 0, 32'h000, 32'h100, 1, 0, 32'h104));
        vecs.push_back(mk(1, 32'h100, 0, 32'h000, 32'h100, 1, 0, 32'h104));
        vecs.push_back(mk(1, 32'h100, 1, 32'h080, 32'h100, 1, 0, 32'h104));
        vecs.push_back(mk(1, 32'h100, 1, 32'h080, 32'h100, 1, 0, 32'h104));
        vecs.push_back(mk(1, 32'h100, 1, 32'h080, 32'h100, 1, 1, 32'h080));
        vecs.push_back(mk(1, 32'h100, 1, 32'h0C0, 32'h100, 1, 1, 32'h080));
        vecs.push_back(mk(1, 32'h100, 0, 32'h000, 32'h100, 1, 1, 32'h0C0));
        vecs.push_back(mk(1, 32'h100, 0, 32'h000, 32'h100, 1, 1, 32'h0C0));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h100, 1, 0, 32'h104));
        vecs.push_back(mk(1, 32'h200, 1, 32'h300, 32'h200, 0, 0, 32'h204));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h100, 0, 0, 32'h104));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h200, 1, 1, 32'h300));
        vecs.push_back(mk(1, 32'h100, 0, 32'h000, 32'h200, 1, 1, 32'h300));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h200, 1, 1, 32'h300));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'hFFFF_FFFC, 0, 0, 32'h0000_0000));
        vecs.push_back(mk(1, 32'h0FC, 1, 32'h040, 32'h0FC, 0, 0, 32'h100));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h0FF, 1, 1, 32'h040));
        vecs.push_back(mk(1, 32'h103, 1, 32'h444, 32'h101, 0, 0, 32'h105));
        vecs.push_back(mk(0, 32'h000, 0, 32'h000, 32'h100, 1, 1, 32'h444));

        rst = 1'b1;
        m_reset();
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h100);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("in_reset", 1'b0, 1'b0, 32'h104, 1'b1);

        @(negedge clk);
        rst = 1'b0;
        m_reset();
        runInit("init1");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].upc, vecs[i].tk, vecs[i].utg, vecs[i].lpc);
            checkOutput($sformatf("vec%0d", i), vecs[i].hit, vecs[i].taken, vecs[i].tgt, 1'b0);
            finishCycle();
        end

        // Asynchronous reset pulse in the middle of RUN, raised between clock edges.
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h100);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 1'b0, 1'b0, 32'h104, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        runInit("init2");
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h100);
        checkOutput("post_rst_100", 1'b0, 1'b0, 32'h104, 1'b0);
        finishCycle();
        applyStimulus(0, 32'h0, 0, 32'h0, 32'h0FC);
        checkOutput("post_rst_0fc", 1'b0, 1'b0, 32'h100, 1'b0);
        finishCycle();

        for (int n = 0; n < 600; n++) begin
            logic [31:0] upc, lpc;
            upc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            lpc = ($urandom_range(0, 3) == 0) ? upc
                : (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            applyStimulus($urandom_range(0, 3) != 0, upc, $urandom_range(0, 1) == 1,
                          $urandom & 32'hFFFF_FFFC, lpc);
            m_predict(lpc, eh, et, eg);
            checkOutput($sformatf("rnd%0d", n), eh, et, eg, init_left > 0);
            finishCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
